bcd_countdown_timer: RTL and testbench

//  4-digit packed-BCD countdown timer: the count-down counterpart of the clock's BCD up-counting path.

---
 rtl/bcd_countdown_timer_pkg.sv | 23 ++
 rtl/bcd_countdown_timer_if.sv | 24 ++
 rtl/bcd_countdown_timer_decrement.sv | 34 +++
 rtl/bcd_countdown_timer.sv | 120 ++++++++++++
 tb/tb_bcd_countdown_timer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD countdown timer: state encoding, BCD
// constants and a preset validity helper.
package bcd_countdown_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   localparam logic [15:0] BCD_ZERO       = 16'h0000;
   localparam logic [3:0]  BCD_NIBBLE_MAX = 4'd9;

   // True when every nibble of a packed 4-digit value is a legal BCD digit.
   function automatic logic bcd_is_valid(input logic [15:0] value);
      return (value[3:0]   <= BCD_NIBBLE_MAX) &&
             (value[7:4]   <= BCD_NIBBLE_MAX) &&
             (value[11:8]  <= BCD_NIBBLE_MAX) &&
             (value[15:12] <= BCD_NIBBLE_MAX);
   endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle of the BCD countdown timer. The master side issues
// commands and the preset; the slave side (the timer) returns count and pulses.
interface bcd_countdown_timer_if;
   logic        tick;
   logic        clear;
   logic        load;
   logic [15:0] preset;
   logic        start;
   logic        pause;
   logic [15:0] count;
   logic        running;
   logic        done;
   logic        load_err;

   modport master (
      output tick, clear, load, preset, start, pause,
      input  count, running, done, load_err
   );

   modport slave (
      input  tick, clear, load, preset, start, pause,
      output count, running, done, load_err
   );
endinterface

// File: rtl/bcd_countdown_timer_decrement.sv
// bcd_decrement_16bit: combinational one-step decrement of a packed 4-digit
// BCD value. Each digit either decrements or, when it is 0, becomes 9 and
// passes a borrow upward. An input of 0000 is returned unchanged (no wrap).
module bcd_decrement_16bit
   import bcd_countdown_timer_pkg::*;
(
   input  logic [15:0] bcd_in,
   output logic [15:0] bcd_out,
   output logic        is_zero_out
);

   logic [4:0] w_borrow;

   // Ripple the borrow through the four digit stages, least significant first.
   always_comb begin
      // NOTE: every output gets a default before the branches so no path leaves
      // it unassigned; an unassigned path in always_comb would infer a latch.
      w_borrow    = '0;
      bcd_out     = bcd_in;
      w_borrow[0] = (bcd_in != BCD_ZERO);
      for (int i = 0; i < 4; i++) begin
         if (w_borrow[i]) begin
            if (bcd_in[4*i +: 4] == 4'd0) begin
               bcd_out[4*i +: 4] = BCD_NIBBLE_MAX;
               w_borrow[i+1]     = 1'b1;
            end else begin
               bcd_out[4*i +: 4] = bcd_in[4*i +: 4] - 4'd1;
            end
         end
      end
      is_zero_out = (bcd_out == BCD_ZERO);
   end

endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: 4-digit packed-BCD countdown timer with a tick
// prescaler, run/pause control and one-cycle done / load_err pulses.
// Optional feature macro: BCD_TIMER_AUTORELOAD_EN (periodic reload from a
// shadow copy of the last accepted preset).
// Commands are strictly prioritised clear > load > start > pause > tick: the
// highest asserted command owns the cycle, even when it has no effect.
module bcd_countdown_timer
   import bcd_countdown_timer_pkg::*;
#(
   parameter int unsigned TICK_PER_STEP = 1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   bcd_countdown_timer_if.slave  bus
);

   localparam logic [7:0] STEP_LAST = 8'(TICK_PER_STEP);

   state_t      r_state;
   logic [15:0] r_count;
   logic [7:0]  r_prescale;
   logic        r_running;
   logic        r_done;
   logic        r_load_err;
`ifdef BCD_TIMER_AUTORELOAD_EN
   logic [15:0] r_shadow;
`endif

   logic [15:0] w_dec_count;
   logic        w_dec_zero;
   logic [7:0]  w_prescale_inc;
   logic        w_step;

   bcd_decrement_16bit u_dec (
      .bcd_in      (r_count),
      .bcd_out     (w_dec_count),
      .is_zero_out (w_dec_zero)
   );

   assign w_prescale_inc = r_prescale + 8'd1;
   assign w_step         = (w_prescale_inc == STEP_LAST);

   // Control FSM with count, prescaler and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_count    <= BCD_ZERO;
         r_prescale <= 8'd0;
         r_running  <= 1'b0;
         r_done     <= 1'b0;
         r_load_err <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
         r_shadow   <= BCD_ZERO;
`endif
      end else begin
         // NOTE: state registers use non-blocking assignments so every branch
         // reads the pre-edge values and the update order cannot matter.
         r_done     <= 1'b0;
         r_load_err <= 1'b0;
         if (bus.clear) begin
            r_count    <= BCD_ZERO;
            r_prescale <= 8'd0;
            r_state    <= ST_IDLE;
            r_running  <= 1'b0;
         end else if (bus.load) begin
            if (r_state != ST_RUN && bcd_is_valid(bus.preset)) begin
               r_count    <= bus.preset;
               r_prescale <= 8'd0;
               r_state    <= ST_IDLE;
               r_running  <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
               r_shadow   <= bus.preset;
`endif
            end else begin
               r_load_err <= 1'b1;
            end
         end else if (bus.start) begin
            if ((r_state == ST_IDLE || r_state == ST_PAUSE) && r_count != BCD_ZERO) begin
               r_state   <= ST_RUN;
               r_running <= 1'b1;
            end
         end else if (bus.pause) begin
            if (r_state == ST_RUN) begin
               r_state   <= ST_PAUSE;
               r_running <= 1'b0;
            end
         end else if (bus.tick && r_state == ST_RUN) begin
            if (w_step) begin
               r_prescale <= 8'd0;
               if (w_dec_zero) begin
                  r_done <= 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
                  if (r_shadow != BCD_ZERO) begin
                     r_count <= r_shadow;
                  end else begin
                     r_count   <= BCD_ZERO;
                     r_state   <= ST_EXPIRED;
                     r_running <= 1'b0;
                  end
`else
                  r_count   <= BCD_ZERO;
                  r_state   <= ST_EXPIRED;
                  r_running <= 1'b0;
`endif
               end else begin
                  r_count <= w_dec_count;
               end
            end else begin
               r_prescale <= w_prescale_inc;
            end
         end
      end
   end

   assign bus.count    = r_count;
   assign bus.running  = r_running;
   assign bus.done     = r_done;
   assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer. Two instances (TICK_PER_STEP 1
// and 3) see identical stimulus; a decimal-integer reference model predicts
// each cycle's outputs, the driver queues them and a monitor compares.
module tb_bcd_countdown_timer;

   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

   typedef struct {
      int val;
      int st;
      int pre;
      int shadow;
      bit done;
      bit err;
   } model_t;

   typedef struct {
      logic [15:0] count;
      logic        running;
      logic        done;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   exp_t   q1[$];
   exp_t   q3[$];
   model_t m1, m3;

   bcd_countdown_timer_if bus1 ();
   bcd_countdown_timer_if bus3 ();

   bcd_countdown_timer #(.TICK_PER_STEP(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   bcd_countdown_timer #(.TICK_PER_STEP(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   always #5 clk = ~clk;

   function automatic int bcd2int(input logic [15:0] v);
      return 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   function automatic bit digits_ok(input logic [15:0] v);
      for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic model_t model_reset();
      model_t m;
      m.val = 0; m.st = M_IDLE; m.pre = 0; m.shadow = 0; m.done = 0; m.err = 0;
      return m;
   endfunction

   // Behavioural rules: decimal value counts down by one every tps running ticks.
   function automatic model_t model_step(input model_t m, input int tps, input bit t, c, l,
                                         input logic [15:0] p, input bit s, pz);
      model_t n = m;
      n.done = 0;
      n.err  = 0;
      if (c) begin
         n.val = 0; n.pre = 0; n.st = M_IDLE;
      end else if (l) begin
         if (m.st != M_RUN && digits_ok(p)) begin
            n.val = bcd2int(p); n.pre = 0; n.st = M_IDLE; n.shadow = n.val;
         end else begin
            n.err = 1;
         end
      end else if (s) begin
         if ((m.st == M_IDLE || m.st == M_PAUSE) && m.val != 0) n.st = M_RUN;
      end else if (pz) begin
         if (m.st == M_RUN) n.st = M_PAUSE;
      end else if (t && m.st == M_RUN) begin
         n.pre = m.pre + 1;
         if (n.pre == tps) begin
            n.pre = 0;
            n.val = m.val - 1;
            if (n.val == 0) begin
               n.done = 1;
`ifdef BCD_TIMER_AUTORELOAD_EN
               if (m.shadow != 0) n.val = m.shadow;
               else n.st = M_EXP;
`else
               n.st = M_EXP;
`endif
            end
         end
      end
      return n;
   endfunction

   function automatic exp_t to_exp(input model_t m);
      exp_t e;
      e.count = int2bcd(m.val); e.running = (m.st == M_RUN); e.done = m.done; e.err = m.err;
      return e;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_dut(input string tag, input exp_t e, input logic [15:0] c,
                            input logic r, input logic d, input logic le);
      check({tag, "_count"},    c,            e.count);
      check({tag, "_running"},  {15'd0, r},   {15'd0, e.running});
      check({tag, "_done"},     {15'd0, d},   {15'd0, e.done});
      check({tag, "_load_err"}, {15'd0, le},  {15'd0, e.err});
   endtask

   // Apply one cycle of stimulus to both DUTs and queue the predicted results.
   task automatic drive(input bit t, c, l, input logic [15:0] p, input bit s, pz);
      @(negedge clk);
      bus1.tick = t; bus1.clear = c; bus1.load = l; bus1.preset = p; bus1.start = s; bus1.pause = pz;
      bus3.tick = t; bus3.clear = c; bus3.load = l; bus3.preset = p; bus3.start = s; bus3.pause = pz;
      m1 = model_step(m1, 1, t, c, l, p, s, pz);
      m3 = model_step(m3, 3, t, c, l, p, s, pz);
      q1.push_back(to_exp(m1));
      q3.push_back(to_exp(m3));
   endtask

   task automatic do_tick();  drive(1, 0, 0, 16'h0000, 0, 0); endtask
   task automatic do_load(input logic [15:0] p); drive(0, 0, 1, p, 0, 0); endtask
   task automatic do_start(); drive(0, 0, 0, 16'h0000, 1, 0); endtask
   task automatic do_pause(); drive(0, 0, 0, 16'h0000, 0, 1); endtask
   task automatic do_idle();  drive(0, 0, 0, 16'h0000, 0, 0); endtask

   function automatic logic [15:0] rand_preset();
      if ($urandom_range(0, 9) == 0) return 16'($urandom);
      if ($urandom_range(0, 3) == 0) return int2bcd(int'($urandom_range(0, 9999)));
      return int2bcd(int'($urandom_range(0, 12)));
   endfunction

   // Monitor: one result per driven cycle, sampled just after the clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check_dut("tps1", e, bus1.count, bus1.running, bus1.done, bus1.load_err);
         end
         if (q3.size() > 0) begin
            e = q3.pop_front();
            check_dut("tps3", e, bus3.count, bus3.running, bus3.done, bus3.load_err);
         end
      end
   end

   initial begin
      exp_t zero_e;
      zero_e.count = 16'h0000; zero_e.running = 1'b0; zero_e.done = 1'b0; zero_e.err = 1'b0;
      bus1.tick = 0; bus1.clear = 0; bus1.load = 0; bus1.preset = '0; bus1.start = 0; bus1.pause = 0;
      bus3.tick = 0; bus3.clear = 0; bus3.load = 0; bus3.preset = '0; bus3.start = 0; bus3.pause = 0;
      m1 = model_reset();
      m3 = model_reset();
      #12;
      check_dut("reset_tps1", zero_e, bus1.count, bus1.running, bus1.done, bus1.load_err);
      check_dut("reset_tps3", zero_e, bus3.count, bus3.running, bus3.done, bus3.load_err);
      @(negedge clk);
      rst_n = 1'b1;

      // Countdown to expiry, then start on 0000 must be refused.
      do_load(16'h0003); do_start();
      repeat (3) do_tick();
      do_idle(); do_start(); do_tick();
      // Borrow across digits.
      do_load(16'h1000); do_start(); do_tick();
      do_pause(); do_load(16'h0100); do_start(); do_tick();
      // Rejected loads: bad nibble, then load while running.
      do_pause(); do_load(16'h00A5); do_load(16'h0f00);
      do_start(); do_load(16'h0042); do_tick(); do_tick();
      // Pause holds the count, resume continues.
      do_clear_load(16'h0005); do_start();
      do_pause(); repeat (4) do_tick();
      do_start(); do_tick();
      // clear + load + start in one cycle.
      drive(1, 1, 1, 16'h0077, 1, 1);
      do_tick();
      // Prescaled path and reload/expiry path.
      do_load(16'h0002); do_start();
      repeat (6) do_tick();
      do_load(16'h0002); do_start();
      repeat (4) do_tick();
      do_idle();

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 1) == 1, $urandom_range(0, 40) == 0, $urandom_range(0, 9) == 0,
               rand_preset(), $urandom_range(0, 6) == 0, $urandom_range(0, 12) == 0);
      end

      // Asynchronous reset in the middle of a run.
      do_clear_load(16'h0009); do_start(); do_tick(); do_tick();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_dut("midrst_tps1", zero_e, bus1.count, bus1.running, bus1.done, bus1.load_err);
      check_dut("midrst_tps3", zero_e, bus3.count, bus3.running, bus3.done, bus3.load_err);
      m1 = model_reset();
      m3 = model_reset();
      @(negedge clk);
      bus1.tick = 0; bus1.load = 0; bus1.start = 0; bus1.pause = 0; bus1.clear = 0;
      bus3.tick = 0; bus3.load = 0; bus3.start = 0; bus3.pause = 0; bus3.clear = 0;
      rst_n = 1'b1;
      do_tick(); do_start(); do_idle();

      repeat (2) @(posedge clk);
      #2;
      check("queue_drained", 16'(q1.size() + q3.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Leave any state through clear, then load a fresh preset.
   task automatic do_clear_load(input logic [15:0] p);
      drive(0, 1, 0, 16'h0000, 0, 0);
      do_load(p);
   endtask

   // Hard time limit so the run always ends with a summary.
   initial begin
      #2_000_000;
      n_errors++;
      $display("FAIL timeout reached actual=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
